gd_sweep_ctrl: RTL and testbench
================================

GD_SWEEP_CTRL -- requirements
Module: gd_sweep_ctrl

Interface
REQ-001 Parameter NUM_POINTS, default 4: number of start points swept per run (1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for done_op per point.
REQ-003 Parameter GAP_CYCLES, default 2: minimum cycles start_op is held low between points (>=2).
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  host one-cycle request to begin a sweep.
REQ-007 x_start_in  in  32  signed Q16.16 first start point, sampled on an accepted start.
REQ-008 x_step_in  in  32  signed Q16.16 increment between points, sampled on an accepted start.
REQ-009 lr_in  in  32  Q16.16 learning rate, sampled on an accepted start.
REQ-010 start_op  out  1  level request to the optimizer.
REQ-011 initial_x_out  out  32  start point for the current run, stable while start_op=1.
REQ-012 learning_rate_out  out  32  sampled lr_in, stable while start_op=1.
REQ-013 done_op  in  1  optimizer completion level; may still be 1 from the previous run.
REQ-014 x_at_min_in, y_min_in  in  32 each  optimizer results, valid while done_op=1.
REQ-015 best_x, best_y  out  32 each  best result of the sweep.
REQ-016 best_idx  out  8  index of the point that produced best_y.
REQ-017 busy  out  1  high from the cycle after start acceptance until done.
REQ-018 done  out  1  one-cycle pulse at sweep end.
REQ-019 timeout_err  out  1  sticky until next accepted start; sweep aborted.

Function
REQ-020 States SHALL be IDLE, ISSUE, WAIT_CLR, WAIT_DONE, CAPTURE, RELEASE, FINISH.
REQ-021 IDLE: start=1 SHALL be accepted; latch inputs, k=0, best_y=0x7FFFFFFF, best_x=0, best_idx=0, timeout_err=0; go to ISSUE.
REQ-022 start while not IDLE SHALL be ignored.
REQ-023 ISSUE: drive initial_x_out = x_start + k*x_step (32-bit two's-complement wrap, computed by running accumulation), assert start_op, clear timeout counter; go to WAIT_CLR.
REQ-024 WAIT_CLR: stay until done_op=0 (discards stale done_op from a previous run), then WAIT_DONE.
REQ-025 WAIT_DONE: stay until done_op=1, then CAPTURE.
REQ-026 Timeout counter SHALL count every cycle in WAIT_CLR and WAIT_DONE; reaching TIMEOUT_CYCLES SHALL set timeout_err, drop start_op, go to FINISH.
REQ-027 CAPTURE (one cycle): if signed y_min_in < best_y (strict), load best_y, best_x=x_at_min_in, best_idx=k; ties keep earlier point; go to RELEASE.
REQ-028 RELEASE: start_op=0 for exactly GAP_CYCLES; then k+1<NUM_POINTS -> k++, ISSUE; else FINISH.
REQ-029 FINISH: pulse done one cycle, drop busy, go to IDLE; best_* and timeout_err hold until next accepted start.
REQ-030 start_op SHALL be 1 only in ISSUE, WAIT_CLR, WAIT_DONE, CAPTURE; minimum start_op high time 3 cycles.
REQ-031 Results on timeout SHALL reflect only points captured before the abort.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, start_op=0, busy=0, done=0, timeout_err=0, best_x=0, best_y=0, best_idx=0, initial_x_out=0, learning_rate_out=0, mid-sweep included.
REQ-033 After rst_n release the first accepted start SHALL behave as from power-up.

Verification
REQ-034 Responder model (y=x^2, done_op after 20 cycles), x_start=0xFFFE0000, step=0x00010000, NUM_POINTS=4 -> initial_x_out -2,-1,0,1; best_x=0, best_y=0, best_idx=2, one done pulse.
REQ-035 x_start=0xFFFF0000, step=0x00020000 -> y 1,1,9,25; best_idx=0, best_x=0xFFFF0000, best_y=0x00010000 (tie keeps first).
REQ-036 done_op held 1 at start (stale) -> controller waits for 0 then 1; no capture before the responder clears done_op.
REQ-037 Responder never raises done_op on point 1 -> after 64 cycles timeout_err=1, start_op=0, done pulse, best_idx=0 from point 0.
REQ-038 rst_n pulsed low in WAIT_DONE of point 2 -> all outputs reset same cycle; new start runs full 4-point sweep correctly.
REQ-039 start pulsed while busy -> ignored; x_step=0x7FFF0000 -> initial_x_out wraps two's-complement, no hang.

Source files
------------

// File: rtl/gd_sweep_ctrl.sv
// Sweep controller: runs an external gradient-descent optimizer from NUM_POINTS evenly
// spaced start points and keeps the lowest result it reports.
module gd_sweep_ctrl #(
  parameter int NUM_POINTS     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x_start_in,
  input  logic [31:0] x_step_in,
  input  logic [31:0] lr_in,
  output logic        start_op,
  output logic [31:0] initial_x_out,
  output logic [31:0] learning_rate_out,
  input  logic        done_op,
  input  logic [31:0] x_at_min_in,
  input  logic [31:0] y_min_in,
  output logic [31:0] best_x,
  output logic [31:0] best_y,
  output logic [7:0]  best_idx,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [8:0]       NUM_PTS_W = 9'(NUM_POINTS);
  localparam logic [31:0]      Y_MAX     = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CLR,
    WAIT_DONE,
    CAPTURE,
    RELEASE,
    FINISH
  } state_t;

  state_t            state;
  logic [31:0]       x_step_q;
  logic [7:0]        k;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              to_expired;
  logic              more_points;
  logic              y_better;

  assign to_expired  = (to_cnt == TO_LAST);
  assign more_points = ({1'b0, k} + 9'd1) < NUM_PTS_W;
  assign y_better    = $signed(y_min_in) < $signed(best_y);

  // Outputs are registered one step ahead of the state they belong to, so start_op,
  // initial_x_out, busy and done change on the same edge the state is entered.
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  // NOTE: every register, datapath included, is cleared by the async reset because
  // all of them are visible outputs or feed outputs that must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      x_step_q          <= '0;
      k                 <= '0;
      to_cnt            <= '0;
      gap_cnt           <= '0;
      start_op          <= 1'b0;
      initial_x_out     <= '0;
      learning_rate_out <= '0;
      best_x            <= '0;
      best_y            <= '0;
      best_idx          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_step_q          <= x_step_in;
            learning_rate_out <= lr_in;
            initial_x_out     <= x_start_in;
            k                 <= '0;
            best_x            <= '0;
            best_y            <= Y_MAX;
            best_idx          <= '0;
            timeout_err       <= 1'b0;
            busy              <= 1'b1;
            start_op          <= 1'b1;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT_CLR;
        end

        // WAIT_CLR first flushes a done_op left high by the previous run, so a
        // stale result is never captured for the new point.
        WAIT_CLR, WAIT_DONE: begin
          to_cnt <= to_cnt + 1'b1;
          if (to_expired) begin
            timeout_err <= 1'b1;
            start_op    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= FINISH;
          end else if (state == WAIT_CLR && !done_op) begin
            state <= WAIT_DONE;
          end else if (state == WAIT_DONE && done_op) begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (y_better) begin
            best_y   <= y_min_in;
            best_x   <= x_at_min_in;
            best_idx <= k;
          end
          start_op <= 1'b0;
          gap_cnt  <= '0;
          state    <= RELEASE;
        end

        RELEASE: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            if (more_points) begin
              k             <= k + 8'd1;
              initial_x_out <= initial_x_out + x_step_q;
              start_op      <= 1'b1;
              state         <= ISSUE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end

        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gd_sweep_ctrl.sv
// Scoreboarded bench for gd_sweep_ctrl with a y=x^2 optimizer responder.
module tb_gd_sweep_ctrl;

  localparam int NP       = 4;
  localparam int TO       = 64;
  localparam int GAP      = 2;
  localparam int RESP_LAT = 20;
  localparam int NO_HANG  = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_start_in = '0;
  logic [31:0] x_step_in = '0;
  logic [31:0] lr_in = '0;
  logic        start_op;
  logic [31:0] initial_x_out;
  logic [31:0] learning_rate_out;
  logic        done_op = 1'b0;
  logic [31:0] x_at_min_in = '0;
  logic [31:0] y_min_in = '0;
  logic [31:0] best_x;
  logic [31:0] best_y;
  logic [7:0]  best_idx;
  logic        busy;
  logic        done;
  logic        timeout_err;

  always #5 clk = ~clk;

  gd_sweep_ctrl #(
    .NUM_POINTS    (NP),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .x_start_in       (x_start_in),
    .x_step_in        (x_step_in),
    .lr_in            (lr_in),
    .start_op         (start_op),
    .initial_x_out    (initial_x_out),
    .learning_rate_out(learning_rate_out),
    .done_op          (done_op),
    .x_at_min_in      (x_at_min_in),
    .y_min_in         (y_min_in),
    .best_x           (best_x),
    .best_y           (best_y),
    .best_idx         (best_idx),
    .busy             (busy),
    .done             (done),
    .timeout_err      (timeout_err)
  );

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] lr;
  } issue_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  idx;
    logic        to;
  } result_t;

  issue_t  exp_issue_q[$];
  result_t exp_res_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Responder controls, written only by the stimulus process
  bit lazy = 1'b0;
  bit stale_req = 1'b0;
  int hang_pt = NO_HANG;
  int sweep_id = 0;
  // Points seen in the current sweep, written only by the responder
  int pt_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
    end
  endtask

  // Q16.16 square, truncated to 32 bits
  function automatic logic [31:0] sq(input logic [31:0] x);
    logic signed [63:0] xs;
    logic signed [63:0] p;
    xs = {{32{x[31]}}, x};
    p  = xs * xs;
    return p[47:16];
  endfunction

  function automatic logic [31:0] point(input logic [31:0] xs, input logic [31:0] st, input int k);
    return xs + st * 32'(k);
  endfunction

  function automatic result_t model(input logic [31:0] xs, input logic [31:0] st,
                                    input int captured, input bit to);
    result_t r;
    r.x   = '0;
    r.y   = 32'h7FFF_FFFF;
    r.idx = '0;
    r.to  = to;
    for (int k = 0; k < captured; k++) begin
      logic [31:0] xk;
      logic [31:0] yk;
      xk = point(xs, st, k);
      yk = sq(xk);
      if ($signed(yk) < $signed(r.y)) begin
        r.x   = xk;
        r.y   = yk;
        r.idx = 8'(k);
      end
    end
    return r;
  endfunction

  // Optimizer responder: reports y = x^2 at x = initial_x, RESP_LAT cycles after start_op rises
  initial begin
    bit so_prev;
    bit pending;
    int clr_cnt;
    int wait_cnt;
    int pt;
    int seen_id;
    logic [31:0] x_cap;
    so_prev = 1'b0; pending = 1'b0; clr_cnt = 0; wait_cnt = 0; pt = 0; seen_id = 0;
    x_cap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_op = 1'b0; so_prev = 1'b0; pending = 1'b0; clr_cnt = 0;
      end else begin
        if (sweep_id != seen_id) begin
          seen_id = sweep_id;
          pt_cnt  = 0;
        end
        if (start_op && !so_prev) begin
          pt = pt_cnt;
          pt_cnt++;
          wait_cnt = 0;
          pending  = 1'b1;
          x_cap    = initial_x_out;
          if (lazy) begin
            clr_cnt     = 5;
            x_at_min_in = 32'hDEAD_BEEF;
            y_min_in    = 32'h8000_0000;
          end else begin
            done_op = 1'b0;
          end
        end else if (!start_op) begin
          if (stale_req) begin
            done_op     = 1'b1;
            x_at_min_in = 32'hDEAD_BEEF;
            y_min_in    = 32'h8000_0000;
          end else if (!lazy) begin
            done_op = 1'b0;
          end
        end
        if (start_op && pending) begin
          if (clr_cnt > 0) begin
            clr_cnt--;
            if (clr_cnt == 0) done_op = 1'b0;
          end
          wait_cnt++;
          if (wait_cnt >= RESP_LAT && pt != hang_pt) begin
            done_op     = 1'b1;
            x_at_min_in = x_cap;
            y_min_in    = sq(x_cap);
            pending     = 1'b0;
          end
        end
        so_prev = start_op;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a point or ends a sweep
  initial begin
    bit so_prev;
    bit had_prev;
    int low_cnt;
    int high_cnt;
    issue_t  ei;
    result_t er;
    so_prev = 1'b0; had_prev = 1'b0; low_cnt = 0; high_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        so_prev = 1'b0; had_prev = 1'b0; low_cnt = 0; high_cnt = 0;
      end else begin
        if (!busy) had_prev = 1'b0;
        if (start_op && !so_prev) begin
          if (had_prev) check("gap_cycles", 32'(low_cnt), 32'(GAP));
          had_prev = 1'b1;
          high_cnt = 0;
          if (exp_issue_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_issue: got x=%08h expected no issue at %0t", initial_x_out, $time);
          end else begin
            ei = exp_issue_q.pop_front();
            check("initial_x_out", initial_x_out, ei.x);
            check("learning_rate_out", learning_rate_out, ei.lr);
            check("busy_at_issue", 32'(busy), 32'd1);
          end
        end
        if (start_op) begin
          high_cnt++;
        end else begin
          if (so_prev) begin
            check("start_op_min_high", 32'(high_cnt >= 3), 32'd1);
            low_cnt = 0;
          end
          low_cnt++;
        end
        if (done) begin
          if (exp_res_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
          end else begin
            er = exp_res_q.pop_front();
            check("best_x", best_x, er.x);
            check("best_y", best_y, er.y);
            check("best_idx", 32'(best_idx), 32'(er.idx));
            check("timeout_err", 32'(timeout_err), 32'(er.to));
            check("busy_at_done", 32'(busy), 32'd0);
            check("start_op_at_done", 32'(start_op), 32'd0);
          end
        end
        so_prev = start_op;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_op"}, 32'(start_op), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_best_x"}, best_x, 32'd0);
    check({tag, "_best_y"}, best_y, 32'd0);
    check({tag, "_best_idx"}, 32'(best_idx), 32'd0);
    check({tag, "_initial_x_out"}, initial_x_out, 32'd0);
    check({tag, "_learning_rate_out"}, learning_rate_out, 32'd0);
  endtask

  // Asserts reset between clock edges and checks outputs clear without a clock edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_issue_q.delete();
    exp_res_q.delete();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic run_sweep(input logic [31:0] xs, input logic [31:0] st, input logic [31:0] lr,
                           input bit lz, input int hp, input bit glitch, input bit abort);
    int issued;
    int captured;
    bit got_done;
    issued   = (hp < NP) ? hp + 1 : NP;
    captured = (hp < NP) ? hp : NP;
    if (abort) issued = 3;
    for (int k = 0; k < issued; k++) exp_issue_q.push_back('{x: point(xs, st, k), lr: lr});
    exp_res_q.push_back(model(xs, st, captured, hp < NP));

    lazy      = lz;
    stale_req = lz;
    hang_pt   = hp;
    sweep_id++;
    repeat (2) @(negedge clk);
    start      = 1'b1;
    x_start_in = xs;
    x_step_in  = st;
    lr_in      = lr;
    @(negedge clk);
    start      = 1'b0;
    stale_req  = 1'b0;
    x_start_in = $urandom();
    x_step_in  = $urandom();
    lr_in      = $urandom();

    got_done = 1'b0;
    for (int cyc = 0; cyc < 1000 && !got_done; cyc++) begin
      @(negedge clk);
      if (glitch && cyc == 8) begin
        start      = 1'b1;
        x_start_in = $urandom();
        x_step_in  = $urandom();
      end else begin
        start = 1'b0;
      end
      if (abort && pt_cnt == 3) begin
        repeat (10) @(negedge clk);
        async_reset();
        return;
      end
      if (done) got_done = 1'b1;
    end
    if (!got_done) begin
      vectors++; miscompares++;
      $display("FAIL sweep_wait: got no done within 1000 cycles expected done pulse at %0t", $time);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] small_q(input logic [31:0] r);
    return {{12{r[19]}}, r[19:0]};
  endfunction

  initial begin
    #12 check_reset_outputs("por");
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    run_sweep(32'hFFFE_0000, 32'h0001_0000, 32'h0000_1000, 1'b0, NO_HANG, 1'b0, 1'b0);
    run_sweep(32'hFFFF_0000, 32'h0002_0000, 32'h0000_0800, 1'b0, NO_HANG, 1'b0, 1'b0);
    run_sweep(32'h0003_0000, 32'hFFFF_8000, 32'h0001_0000, 1'b1, NO_HANG, 1'b0, 1'b0);
    run_sweep(32'hFFFE_0000, 32'h0001_0000, 32'h0000_2000, 1'b0, 1,       1'b0, 1'b0);
    run_sweep(32'hFFFE_0000, 32'h0001_0000, 32'h0000_1000, 1'b0, 0,       1'b0, 1'b0);
    run_sweep(32'hFFFE_0000, 32'h0001_0000, 32'h0000_4000, 1'b0, NO_HANG, 1'b0, 1'b1);
    run_sweep(32'hFFFE_0000, 32'h0001_0000, 32'h0000_4000, 1'b0, NO_HANG, 1'b0, 1'b0);
    run_sweep(32'h0000_0000, 32'h7FFF_0000, 32'h0000_1000, 1'b0, NO_HANG, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] xs;
      logic [31:0] st;
      int hp;
      xs = $urandom();
      st = $urandom();
      if (i % 3 != 0) begin
        xs = small_q(xs);
        st = small_q(st);
      end
      hp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : NO_HANG;
      run_sweep(xs, st, $urandom(), 1'($urandom_range(0, 1)), hp, 1'($urandom_range(0, 1)), 1'b0);
    end

    check("issue_queue_drained", 32'(exp_issue_q.size()), 32'd0);
    check("result_queue_drained", 32'(exp_res_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
